// File: rtl/mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_ctrl_if : bundle of the request-side and memory-side signals of the
// memory-access sequencer.
//
//   Control-unit side : rd_req, wr_req, mar_addr, mdr_data
//   Memory side       : mem_addr, mem_wdata, mem_en, mem_we  (to memory)
//                       mem_rdata, mem_ready                 (from memory)
//   MDR side          : mdata_in, read, mdr_load
//   Status            : busy, done, err
//
//   modport slave  : the sequencer's view (drives memory, MDR and status)
//   modport master : the surrounding system's view (control unit + memory)
// ---------------------------------------------------------------------------
interface mem_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) ();
    logic              rd_req;
    logic              wr_req;
    logic [ADDR_W-1:0] mar_addr;
    logic [DATA_W-1:0] mdr_data;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_en;
    logic              mem_we;
    logic [DATA_W-1:0] mdata_in;
    logic              read;
    logic              mdr_load;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  rd_req, wr_req, mar_addr, mdr_data, mem_rdata, mem_ready,
        output mem_addr, mem_wdata, mem_en, mem_we,
        output mdata_in, read, mdr_load, busy, done, err
    );

    modport master (
        output rd_req, wr_req, mar_addr, mdr_data, mem_rdata, mem_ready,
        input  mem_addr, mem_wdata, mem_en, mem_we,
        input  mdata_in, read, mdr_load, busy, done, err
    );
endinterface

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl : single-word memory-access sequencer between the MAR/MDR pair and
// main memory.
//
// A read or write request sampled in IDLE launches one memory access: the
// address (and write data) are registered, mem_en is raised and held for at
// least WAIT_CYCLES cycles, after which mem_ready completes the access. A
// read then presents the fetched word on mdata_in with read/mdr_load high
// for exactly one cycle. Every access ends in a one-cycle done pulse; an
// access that sees no completion within TIMEOUT wait cycles is aborted and
// flagged with err alongside done.
//
// Ports:
//   clk  : system clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : mem_ctrl_if.slave (requests, memory handshake, MDR feed, status)
//
// Parameters:
//   ADDR_W      : memory word-address width
//   DATA_W      : data width
//   WAIT_CYCLES : minimum mem_en cycles before mem_ready is honoured (1..255)
//   TIMEOUT     : wait cycles before abort (> WAIT_CYCLES, <= 255)
// ---------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        clr,
    mem_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_LATCH,
        WR_WAIT,
        DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST    = 8'(WAIT_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;

    // mem_ready is only honoured once the minimum hold time has elapsed;
    // an earlier ready is treated as noise.
    logic complete;
    logic timed_out;

    assign complete  = (cnt >= WAIT_LAST) && bus.mem_ready;
    assign timed_out = (cnt == TIMEOUT_LAST);

    // NOTE: every register here, including the data registers, is cleared by
    // clr so that mem_en and the MDR feed drop immediately on reset, with no
    // clock required.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.mem_addr <= '0;
            bus.mem_wdata<= '0;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mdata_in <= '0;
            bus.read     <= 1'b0;
            bus.mdr_load <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout: every branch reads
            // the pre-edge values of state/cnt, so branch order cannot leak a
            // freshly written value into another decision in the same edge.
            case (state)
                IDLE: begin
                    // Read has priority; a simultaneous write request is
                    // simply dropped.
                    if (bus.rd_req) begin
                        bus.mem_addr <= bus.mar_addr;
                        bus.mem_en   <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.busy     <= 1'b1;
                        cnt          <= '0;
                        state        <= RD_WAIT;
                    end else if (bus.wr_req) begin
                        bus.mem_addr  <= bus.mar_addr;
                        bus.mem_wdata <= bus.mdr_data;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.busy      <= 1'b1;
                        cnt           <= '0;
                        state         <= WR_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (complete) begin
                        bus.mdata_in <= bus.mem_rdata;
                        bus.mem_en   <= 1'b0;
                        bus.read     <= 1'b1;
                        bus.mdr_load <= 1'b1;
                        state        <= RD_LATCH;
                    end else if (timed_out) begin
                        // Abort: mdata_in keeps the last good word.
                        bus.mem_en <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.err    <= 1'b1;
                        state      <= DONE;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end

                RD_LATCH: begin
                    bus.read     <= 1'b0;
                    bus.mdr_load <= 1'b0;
                    bus.done     <= 1'b1;
                    state        <= DONE;
                end

                WR_WAIT: begin
                    if (complete || timed_out) begin
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.err    <= !complete;
                        state      <= DONE;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end

                DONE: begin
                    // Requests seen here are ignored; the next one is taken
                    // from IDLE.
                    bus.done <= 1'b0;
                    bus.err  <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl : self-checking bench for mem_ctrl (WAIT_CYCLES=2, TIMEOUT=16).
// Directed vectors from a table, a reset-during-access sequence, and random
// transactions checked against a transaction-level timing model.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

    localparam int ADDR_W      = 9;
    localparam int DATA_W      = 32;
    localparam int WAIT_CYCLES = 2;
    localparam int TIMEOUT     = 16;
    localparam int NO_READY    = 1000;

    logic clk = 1'b0;
    logic clr = 1'b0;

    mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .WAIT_CYCLES(WAIT_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_mdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: the access completes at the first wait cycle
    // c >= WAIT_CYCLES-1 where memory is ready; with none before cycle
    // TIMEOUT-1 it aborts there. Cycle 0 follows the request-sampling edge.
    function automatic void model(input bit rd, input int ready_at, input int glitch_at,
                                  output int en_cyc, output int done_cyc,
                                  output bit err, output bit load);
        int k = -1;
        int last;
        for (int c = WAIT_CYCLES - 1; c < TIMEOUT; c++)
            if (k < 0 && (c >= ready_at || c == glitch_at)) k = c;
        err      = (k < 0);
        last     = err ? TIMEOUT - 1 : k;
        en_cyc   = last + 1;
        load     = rd && !err;
        done_cyc = last + (load ? 2 : 1);
    endfunction

    // Runs one access; must be entered #1 after a rising edge with the DUT idle.
    task automatic run_txn(input string tag, input bit rd, input bit wr,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [DATA_W-1:0] rdata, input int ready_at, input int glitch_at,
                           input int exp_en, input int exp_done, input bit exp_err, input bit exp_load);
        int en_cnt = 0, we_cnt = 0, load_cnt = 0, read_mis = 0, done_cnt = 0;
        int addr_bad = 0, wdata_bad = 0, done_cyc = -1;
        logic err_at_done = 1'b0, busy_at_done = 1'b0, busy_after = 1'b1;
        logic [DATA_W-1:0] mdata_at_load = '0;
        bit rdy;

        bus.rd_req   = rd;
        bus.wr_req   = wr;
        bus.mar_addr = addr;
        bus.mdr_data = data;
        @(posedge clk); #1;
        bus.rd_req   = 1'b0;
        bus.wr_req   = 1'b0;
        bus.mar_addr = ~addr;
        bus.mdr_data = ~data;

        for (int c = 0; c < TIMEOUT + 8; c++) begin
            rdy           = (c >= ready_at) || (c == glitch_at);
            bus.mem_ready = rdy;
            bus.mem_rdata = rdy ? rdata : ~rdata;
            if (bus.mem_en) begin
                en_cnt++;
                if (bus.mem_addr !== addr) addr_bad++;
            end
            if (bus.mem_we) begin
                we_cnt++;
                if (bus.mem_wdata !== data) wdata_bad++;
            end
            if (bus.mdr_load) begin
                load_cnt++;
                mdata_at_load = bus.mdata_in;
            end
            if (bus.read !== bus.mdr_load) read_mis++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = c;
                    err_at_done  = bus.err;
                    busy_at_done = bus.busy;
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = bus.busy;
            @(posedge clk); #1;
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        bus.mem_ready = 1'b0;

        check({tag, " en_cycles"},  64'(en_cnt),   64'(exp_en));
        check({tag, " we_cycles"},  64'(we_cnt),   64'((wr && !rd) ? exp_en : 0));
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({tag, " done_width"}, 64'(done_cnt), 64'd1);
        check({tag, " err"},        64'(err_at_done), 64'(exp_err));
        check({tag, " loads"},      64'(load_cnt), 64'(exp_load));
        check({tag, " read_sel"},   64'(read_mis), 64'd0);
        check({tag, " addr_hold"},  64'(addr_bad), 64'd0);
        check({tag, " wdata_hold"}, 64'(wdata_bad), 64'd0);
        check({tag, " busy_done"},  64'(busy_at_done), 64'd1);
        check({tag, " busy_after"}, 64'(busy_after), 64'd0);
        if (exp_load) begin
            check({tag, " mdata_load"}, 64'(mdata_at_load), 64'(rdata));
            exp_mdata = rdata;
        end
        check({tag, " mdata_hold"}, 64'(bus.mdata_in), 64'(exp_mdata));
    endtask

    typedef struct {
        bit                rd;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] rdata;
        int                ready_at;
        int                glitch_at;
        int                exp_en;
        int                exp_done;
        bit                exp_err;
        bit                exp_load;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int en_c, done_c;
        bit e_err, e_load;
        int done_seen;
        bit rd, wr;

        //            rd    wr    addr    data          rdata         rdy  glt  en done err load
        vecs[0] = '{1'b1, 1'b0, 9'h05A, 32'h0,        32'hDEADBEEF, 0,        -1, 2,  3, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 9'h100, 32'h0,        32'h11112222, NO_READY, -1, 16, 16, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 9'h1FF, 32'h12345678, 32'h0,        0,        -1, 2,  2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 9'h0A3, 32'h0,        32'hCAFEF00D, 5,         0, 6,  7, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 9'h077, 32'hAAAA5555, 32'h0BADF00D, 0,        -1, 2,  3, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 9'h000, 32'hFFFFFFFF, 32'h0,        3,        -1, 4,  4, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 9'h155, 32'h5A5A5A5A, 32'h0,        NO_READY, -1, 16, 16, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 9'h0F0, 32'h0,        32'h87654321, 15,       -1, 16, 17, 1'b0, 1'b1};

        bus.rd_req    = 1'b0;
        bus.wr_req    = 1'b0;
        bus.mar_addr  = '0;
        bus.mdr_data  = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        exp_mdata     = '0;

        // Reset state
        #2 clr = 1'b1;
        #1;
        check("reset_ctrl", 64'({bus.mem_en, bus.mem_we, bus.read, bus.mdr_load,
                                 bus.busy, bus.done, bus.err}), 64'd0);
        check("reset_mdata", 64'(bus.mdata_in), 64'd0);
        check("reset_addr",  64'(bus.mem_addr), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) clr = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Directed table
        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                    vecs[i].data, vecs[i].rdata, vecs[i].ready_at, vecs[i].glitch_at,
                    vecs[i].exp_en, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_load);

        // clr in the middle of a read wait: outputs drop without a clock edge
        bus.rd_req   = 1'b1;
        bus.mar_addr = 9'h0AB;
        @(posedge clk); #1;
        bus.rd_req    = 1'b0;
        bus.mem_ready = 1'b0;
        check("clr_pre_en", 64'(bus.mem_en), 64'd1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr_async_en",    64'(bus.mem_en),   64'd0);
        check("clr_async_busy",  64'(bus.busy),     64'd0);
        check("clr_async_mdata", 64'(bus.mdata_in), 64'd0);
        exp_mdata = '0;
        done_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done || bus.err) done_seen++;
        end
        @(negedge clk) clr = 1'b0;
        @(posedge clk); #1;
        if (bus.done || bus.err) done_seen++;
        check("clr_no_done", 64'(done_seen), 64'd0);
        model(1'b1, 0, -1, en_c, done_c, e_err, e_load);
        run_txn("post_clr", 1'b1, 1'b0, 9'h0AB, 32'h0, 32'h13579BDF, 0, -1,
                en_c, done_c, e_err, e_load);

        // Random transactions against the model
        for (int t = 0; t < 40; t++) begin
            int ra, ga;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d, r;
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            a  = ADDR_W'($urandom);
            d  = $urandom;
            r  = $urandom;
            ra = ($urandom_range(0, 7) == 0) ? NO_READY : int'($urandom_range(0, 18));
            ga = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 3));
            model(rd, ra, ga, en_c, done_c, e_err, e_load);
            run_txn($sformatf("rnd%0d", t), rd, wr, a, d, r, ra, ga,
                    en_c, done_c, e_err, e_load);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
